spike_decoder: RTL

- Receive-side counterpart to the spike-generating comparator: converts a 1-bit spike stream back into digital magnitude samples.
- Counts spikes over a programmable window of clock cycles and emits one count per window through a 2-entry output FIFO with a valid/ready handshake.
- Sits downstream of the spikifier in the same clock domain and feeds the digital back end.

---
 rtl/spike_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spike_decoder.sv
// Spike-count decoder: counts spikes over a programmable window and queues one
// {count, saturated} sample per window in a 2-entry valid/ready output FIFO.
module spike_decoder #(
    parameter int CW      = 8,
    parameter int LW      = 16,
    parameter int DEF_WIN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [LW-1:0] win_len,
    input  logic          spike_in,
    input  logic          sample_ready,
    input  logic          clr_overrun,
    output logic [CW-1:0] sample,
    output logic          sample_sat,
    output logic          sample_valid,
    output logic          busy,
    output logic          overrun
);

    // Handshake: a sample transfers on any posedge where sample_valid && sample_ready;
    // the head entry holds stable while valid && !ready.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACQ  = 1'b1;

    localparam logic [CW-1:0] ACC_MAX = {CW{1'b1}};

    logic [0:0]    state;
    logic [LW-1:0] cyc;
    logic [LW-1:0] len;
    logic [CW-1:0] acc;
    logic          sat;

    logic [CW-1:0] mem_val [0:1];
    logic          mem_sat [0:1];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    logic [CW-1:0] acc_next;
    logic          lost;
    logic          win_end;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;

    always_comb begin
        lost     = 1'b0;
        acc_next = acc;
        if (spike_in) begin
            if (acc == ACC_MAX) lost = 1'b1;
            else                acc_next = acc + CW'(1);
        end
    end

    // en=0 in ACQ abandons the partial window, so it masks a coincident window end.
    assign win_end = (state == ACQ) && en && (cyc == len - LW'(1));
    assign full    = (occ == 2'd2);
    assign pop     = sample_valid && sample_ready;
    assign do_push = win_end && (!full || pop);
    assign drop    = win_end && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
            len   <= '0;
            acc   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        len   <= (win_len == '0) ? LW'(DEF_WIN) : win_len;
                        cyc   <= '0;
                        acc   <= '0;
                        sat   <= 1'b0;
                        state <= ACQ;
                    end
                end
                default: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (win_end) begin
                        cyc <= '0;
                        acc <= '0;
                        sat <= 1'b0;
                    end else begin
                        cyc <= cyc + LW'(1);
                        acc <= acc_next;
                        sat <= sat | lost;
                    end
                end
            endcase
        end
    end

    // With two entries, full implies wr_ptr==rd_ptr, so a push+pop while full
    // overwrites exactly the slot being popped this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_val[0] <= '0;
            mem_val[1] <= '0;
            mem_sat[0] <= 1'b0;
            mem_sat[1] <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            if (do_push) begin
                mem_val[wr_ptr] <= acc_next;
                mem_sat[wr_ptr] <= sat | lost;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({do_push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

    assign sample_valid = (occ != 2'd0);
    assign sample       = sample_valid ? mem_val[rd_ptr] : '0;
    assign sample_sat   = sample_valid ? mem_sat[rd_ptr] : 1'b0;
    assign busy         = (state == ACQ);

endmodule
